// File: rtl/ftdi_rx.sv
// ftdi_rx: FTDI fast serial receiver. Deserialises FSDO frames
// (start, 8 data LSB first, source bit) into a show-ahead byte FIFO.
// Ports:
//   clk, reset (async, active-low)
//   fsdo       serial data from FTDI, idles high
//   bit_en     bit sample enable
//   fscts      clear to send, high = FTDI may start a frame
//   data_out   FIFO head byte (8'h00 when empty)
//   data_valid FIFO not empty
//   data_ready consumer accepts data_out
//   overflow   pulse: matching frame dropped, FIFO full
//   chan_err   pulse: frame dropped, wrong source bit
module ftdi_rx #(
   parameter int   DEPTH   = 4,
   parameter int   AW      = 2,
   parameter logic CHANNEL = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fsdo,
   input  logic       bit_en,
   output logic       fscts,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       overflow,
   output logic       chan_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_SRC
   } state_t;

   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_CTS  = (AW+1)'(DEPTH - 2);

   state_t      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        ovf_d, cerr_d;
   logic        overflow_q, chan_err_q;
   logic        push, pop, full;

   logic [7:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0] count_q, count_d;
   logic        fscts_q;

   // Full is judged on the count at the start of the cycle, so a
   // simultaneous pop never rescues a push into a full FIFO.
   assign full = (count_q == CNT_FULL);
   assign data_valid = (count_q != '0);
   assign pop = data_valid & data_ready;
   assign data_out = data_valid ? mem_q[rd_ptr_q] : 8'h00;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      push      = 1'b0;
      ovf_d     = 1'b0;
      cerr_d    = 1'b0;
      if (bit_en) begin
         unique case (state_q)
            S_IDLE: begin
               if (!fsdo) begin
                  state_d   = S_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            S_DATA: begin
               shift_d[bit_cnt_q] = fsdo;
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_SRC;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
            S_SRC: begin
               if (fsdo == CHANNEL) begin
                  if (full) ovf_d = 1'b1;
                  else      push  = 1'b1;
               end else begin
                  cerr_d = 1'b1;
               end
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) count_d = count_q + 1'b1;
      if (!push && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         overflow_q <= 1'b0;
         chan_err_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         fscts_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         overflow_q <= ovf_d;
         chan_err_q <= cerr_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_d;
         // Leaves one slot free for a frame already in flight.
         fscts_q    <= (count_d <= CNT_CTS);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= shift_q;
   end

   assign fscts    = fscts_q;
   assign overflow = overflow_q;
   assign chan_err = chan_err_q;

endmodule

// File: tb/tb_ftdi_rx.sv
// tb_ftdi_rx: randomized and directed bench for ftdi_rx, checked
// against a queue-based model of the receive FIFO.
module tb_ftdi_rx;

   localparam int   DEPTH   = 4;
   localparam logic CHANNEL = 1'b1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       fsdo = 1'b1;
   logic       bit_en = 1'b0;
   logic       fscts;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready = 1'b0;
   logic       overflow;
   logic       chan_err;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] mq[$];
   logic [7:0] got[$];
   int dev = 0;
   int ovf_seen = 0, cerr_seen = 0;
   int ovf_exp = 0, cerr_exp = 0;
   bit rand_rdy = 0;

   ftdi_rx #(.DEPTH(DEPTH), .AW(2), .CHANNEL(CHANNEL)) dut (
      .clk(clk), .reset(reset), .fsdo(fsdo), .bit_en(bit_en),
      .fscts(fscts), .data_out(data_out), .data_valid(data_valid),
      .data_ready(data_ready), .overflow(overflow), .chan_err(chan_err)
   );

   always #5 clk = ~clk;

   // One clock: advance the FIFO model, then record any divergence.
   task automatic step(input bit fin, input logic [7:0] b, input logic s);
      bit pop, full, push, e_ovf, e_cerr, e_cts;
      logic [7:0] e_dout;
      if (rand_rdy) data_ready = 1'($urandom_range(0, 1));
      if (data_valid && data_ready) got.push_back(data_out);
      pop  = data_ready && (mq.size() != 0);
      full = (mq.size() == DEPTH);
      push = 0; e_ovf = 0; e_cerr = 0;
      if (fin) begin
         if (s == CHANNEL) begin
            if (full) e_ovf = 1; else push = 1;
         end else e_cerr = 1;
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(b);
      ovf_exp += int'(e_ovf);
      cerr_exp += int'(e_cerr);
      e_cts = (mq.size() <= DEPTH - 2);
      e_dout = (mq.size() != 0) ? mq[0] : 8'h00;
      @(posedge clk); #1;
      ovf_seen += int'(overflow);
      cerr_seen += int'(chan_err);
      if (data_valid !== (mq.size() != 0) || data_out !== e_dout ||
          overflow !== e_ovf || chan_err !== e_cerr || fscts !== e_cts)
         dev++;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic s,
                             input int per, input int last_rdy);
      logic [9:0] bits;
      bits = {s, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         fsdo = bits[i];
         bit_en = 1'b1;
         if (i == 9 && last_rdy >= 0) data_ready = last_rdy[0];
         step(i == 9, b, s);
         if (i == 9 && last_rdy >= 0) data_ready = 1'b0;
         for (int k = 1; k < per; k++) begin
            bit_en = 1'b0;
            fsdo = 1'($urandom_range(0, 1));
            step(0, 8'h00, 1'b0);
         end
      end
      fsdo = 1'b1;
   endtask

   task automatic drain();
      fsdo = 1'b1;
      bit_en = 1'b1;
      data_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) step(0, 8'h00, 1'b0);
      data_ready = 1'b0;
   endtask

   function automatic logic [39:0] got_word();
      logic [39:0] w;
      w = '0;
      for (int i = 0; i < got.size() && i < 5; i++)
         w = {w[31:0], got[i]};
      return w;
   endfunction

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (fscts !== 1'b0 || data_valid !== 1'b0 || data_out !== 8'h00 ||
          overflow !== 1'b0 || chan_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_vals: cts=%b v=%b d=%h o=%b c=%b want 0 0 00 0 0",
                  fscts, data_valid, data_out, overflow, chan_err);
      end
      reset = 1'b1;
      bit_en = 1'b1;
      step(0, 8'h00, 1'b0);
      n_chk++;
      if (fscts !== 1'b1) begin
         n_fail++;
         $display("FAIL cts_after_reset: got %b want 1", fscts);
      end
   endtask

   task automatic test_basic();
      dev = 0;
      send_frame(8'hA5, 1'b1, 1, -1);
      n_chk++;
      if (data_valid !== 1'b1 || data_out !== 8'hA5) begin
         n_fail++;
         $display("FAIL basic_rx: v=%b d=%h want 1 a5", data_valid, data_out);
      end
      data_ready = 1'b1;
      step(0, 8'h00, 1'b0);
      data_ready = 1'b0;
      n_chk++;
      if (data_valid !== 1'b0 || data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL basic_pop: v=%b d=%h want 0 00", data_valid, data_out);
      end
      n_chk++;
      if (dev !== 0) begin
         n_fail++;
         $display("FAIL basic_model: %0d deviating cycles want 0", dev);
      end
   endtask

   task automatic test_chan_err();
      int c0;
      dev = 0;
      c0 = cerr_seen;
      send_frame(8'h3C, 1'b0, 1, -1);
      step(0, 8'h00, 1'b0);
      n_chk++;
      if (cerr_seen - c0 !== 1 || data_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL chan_err: pulses=%0d v=%b want 1 0",
                  cerr_seen - c0, data_valid);
      end
      n_chk++;
      if (dev !== 0) begin
         n_fail++;
         $display("FAIL chan_err_model: %0d deviating cycles want 0", dev);
      end
   endtask

   task automatic test_fill_overflow();
      int o0;
      dev = 0;
      data_ready = 1'b0;
      send_frame(8'h01, 1'b1, 1, -1);
      send_frame(8'h02, 1'b1, 1, -1);
      n_chk++;
      if (fscts !== 1'b1) begin
         n_fail++;
         $display("FAIL cts_two: got %b want 1", fscts);
      end
      send_frame(8'h03, 1'b1, 1, -1);
      n_chk++;
      if (fscts !== 1'b0) begin
         n_fail++;
         $display("FAIL cts_three: got %b want 0", fscts);
      end
      o0 = ovf_seen;
      send_frame(8'h04, 1'b1, 1, -1);
      send_frame(8'h05, 1'b1, 1, -1);
      step(0, 8'h00, 1'b0);
      n_chk++;
      if (ovf_seen - o0 !== 1) begin
         n_fail++;
         $display("FAIL overflow: pulses=%0d want 1", ovf_seen - o0);
      end
      got.delete();
      data_ready = 1'b1;
      step(0, 8'h00, 1'b0);
      n_chk++;
      if (fscts !== 1'b0) begin
         n_fail++;
         $display("FAIL cts_pop1: got %b want 0", fscts);
      end
      step(0, 8'h00, 1'b0);
      n_chk++;
      if (fscts !== 1'b1) begin
         n_fail++;
         $display("FAIL cts_pop2: got %b want 1", fscts);
      end
      drain();
      n_chk++;
      if (got.size() !== 4 || got_word() !== 40'h00_01020304) begin
         n_fail++;
         $display("FAIL drain_order: n=%0d bytes=%h want 4 0001020304",
                  got.size(), got_word());
      end
      n_chk++;
      if (dev !== 0) begin
         n_fail++;
         $display("FAIL fill_model: %0d deviating cycles want 0", dev);
      end
   endtask

   task automatic test_pop_on_full();
      int o0;
      dev = 0;
      data_ready = 1'b0;
      for (int i = 1; i <= 4; i++)
         send_frame(8'(i), 1'b1, 1, -1);
      o0 = ovf_seen;
      got.delete();
      send_frame(8'h06, 1'b1, 1, 1);
      step(0, 8'h00, 1'b0);
      n_chk++;
      if (ovf_seen - o0 !== 1) begin
         n_fail++;
         $display("FAIL pop_full_ovf: pulses=%0d want 1", ovf_seen - o0);
      end
      drain();
      n_chk++;
      if (got.size() !== 4 || got_word() !== 40'h00_01020304) begin
         n_fail++;
         $display("FAIL pop_full_drain: n=%0d bytes=%h want 4 0001020304",
                  got.size(), got_word());
      end
      n_chk++;
      if (dev !== 0) begin
         n_fail++;
         $display("FAIL pop_full_model: %0d deviating cycles want 0", dev);
      end
   endtask

   task automatic test_slow_bit_en();
      dev = 0;
      got.delete();
      data_ready = 1'b1;
      send_frame(8'hFF, 1'b1, 3, -1);
      send_frame(8'h00, 1'b1, 3, -1);
      drain();
      n_chk++;
      if (got.size() !== 2 || got_word() !== 40'h00_0000FF00) begin
         n_fail++;
         $display("FAIL slow_b2b: n=%0d bytes=%h want 2 000000ff00",
                  got.size(), got_word());
      end
      n_chk++;
      if (dev !== 0) begin
         n_fail++;
         $display("FAIL slow_model: %0d deviating cycles want 0", dev);
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b;
      dev = 0;
      data_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1, -1);
      send_frame(8'h22, 1'b1, 1, -1);
      b = 8'h5A;
      bit_en = 1'b1;
      fsdo = 1'b0;
      step(0, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         fsdo = b[i];
         step(0, 8'h00, 1'b0);
      end
      #2 reset = 1'b0;
      #1;
      mq.delete();
      n_chk++;
      if (fscts !== 1'b0 || data_valid !== 1'b0 || data_out !== 8'h00 ||
          overflow !== 1'b0 || chan_err !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: cts=%b v=%b d=%h o=%b c=%b want 0 0 00 0 0",
                  fscts, data_valid, data_out, overflow, chan_err);
      end
      fsdo = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      step(0, 8'h00, 1'b0);
      n_chk++;
      if (fscts !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_cts: got %b want 1", fscts);
      end
      got.delete();
      send_frame(8'h77, 1'b1, 1, -1);
      drain();
      n_chk++;
      if (got.size() !== 1 || got_word() !== 40'h00_00000077) begin
         n_fail++;
         $display("FAIL mid_reset_rx: n=%0d bytes=%h want 1 0000000077",
                  got.size(), got_word());
      end
      n_chk++;
      if (dev !== 0) begin
         n_fail++;
         $display("FAIL mid_reset_model: %0d deviating cycles want 0", dev);
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic s;
      int o0, c0, oe0, ce0, sent, recv;
      dev = 0;
      o0 = ovf_seen; c0 = cerr_seen;
      oe0 = ovf_exp; ce0 = cerr_exp;
      got.delete();
      sent = 0;
      rand_rdy = 1;
      for (int f = 0; f < 40; f++) begin
         b = 8'($urandom);
         s = ($urandom_range(0, 5) == 0) ? ~CHANNEL : CHANNEL;
         send_frame(b, s, $urandom_range(1, 3), -1);
         if (s == CHANNEL) sent++;
         bit_en = 1'b1;
         fsdo = 1'b1;
         for (int g = $urandom_range(0, 3); g > 0; g--)
            step(0, 8'h00, 1'b0);
      end
      rand_rdy = 0;
      drain();
      recv = got.size();
      n_chk++;
      if (ovf_seen - o0 !== ovf_exp - oe0 ||
          cerr_seen - c0 !== cerr_exp - ce0) begin
         n_fail++;
         $display("FAIL rand_pulses: ovf=%0d cerr=%0d want %0d %0d",
                  ovf_seen - o0, cerr_seen - c0,
                  ovf_exp - oe0, cerr_exp - ce0);
      end
      n_chk++;
      if (recv + (ovf_exp - oe0) !== sent) begin
         n_fail++;
         $display("FAIL rand_count: recv+drop=%0d want %0d",
                  recv + (ovf_exp - oe0), sent);
      end
      n_chk++;
      if (dev !== 0) begin
         n_fail++;
         $display("FAIL rand_model: %0d deviating cycles want 0", dev);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_chan_err();
      test_fill_overflow();
      test_pop_on_full();
      test_slow_bit_en();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
